// File: rtl/page_rank_engine.sv
// Iterative fixed-point PageRank solver for an N-node graph.
// One adjacency term is accumulated per cycle through a single multiplier.
module page_rank_engine #(
  parameter int N        = 4,
  parameter int WIDTH    = 16,
  parameter int MAX_ITER = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [N*N-1:0]                adj,
  input  logic [N*WIDTH-1:0]            nodeWeight,
  input  logic [WIDTH-1:0]              damping,
  input  logic [WIDTH-1:0]              base,
  input  logic [WIDTH-1:0]              eps,
  output logic                          busy,
  output logic                          done,
  output logic                          converged,
  output logic [$clog2(MAX_ITER+1)-1:0] iter_count,
  output logic [N*WIDTH-1:0]            rank_out
);

  localparam int IW  = $clog2(N);
  localparam int AIW = $clog2(N*N);
  localparam int AW  = WIDTH + $clog2(N);
  localparam int CW  = $clog2(MAX_ITER+1);

  localparam logic [WIDTH:0]   ONE_Q  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0]   INIT_Q = ONE_Q / (WIDTH+1)'(N);
  localparam logic [WIDTH-1:0] INIT   = INIT_Q[WIDTH-1:0];

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_FINISH,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [N*N-1:0]   adj_q;
  logic [WIDTH-1:0] w_q  [N];
  logic [WIDTH-1:0] rank [N];
  logic [WIDTH-1:0] nxt  [N];
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] base_q;
  logic [WIDTH-1:0] eps_q;
  logic [IW-1:0]    i;
  logic [IW-1:0]    j;
  logic [AW-1:0]    acc;

  logic [AIW-1:0]     adj_idx;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   term;
  logic [WIDTH-1:0]   acc_sat;
  logic [2*WIDTH-1:0] scaled;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   fin;
  logic [WIDTH-1:0]   delta;
  logic               early;
  logic               last_iter;

  // NOTE: every combinational output is given a default before any branch, so no latch is inferred.
  always_comb begin
    adj_idx   = AIW'(i) * AIW'(N) + AIW'(j);
    prod      = (2*WIDTH)'(w_q[j]) * (2*WIDTH)'(rank[j]);
    term      = adj_q[adj_idx] ? prod[2*WIDTH-1:WIDTH] : '0;
    acc_sat   = (acc[AW-1:WIDTH] != '0) ? '1 : acc[WIDTH-1:0];
    scaled    = (2*WIDTH)'(d_q) * (2*WIDTH)'(acc_sat);
    sum       = {1'b0, base_q} + {1'b0, scaled[2*WIDTH-1:WIDTH]};
    fin       = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    delta     = '0;
    for (int k = 0; k < N; k++) begin
      if (nxt[k] >= rank[k]) begin
        if (nxt[k] - rank[k] > delta) delta = nxt[k] - rank[k];
      end else if (rank[k] - nxt[k] > delta) begin
        delta = rank[k] - nxt[k];
      end
    end
    early     = (eps_q != '0) && (delta < eps_q);
    last_iter = (iter_count == CW'(MAX_ITER - 1));
  end

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      converged  <= 1'b0;
      iter_count <= '0;
      rank_out   <= '0;
      adj_q      <= '0;
      d_q        <= '0;
      base_q     <= '0;
      eps_q      <= '0;
      i          <= '0;
      j          <= '0;
      acc        <= '0;
      // NOTE: the small rank/weight arrays are flops, so they are cleared explicitly; a RAM would not be.
      for (int k = 0; k < N; k++) begin
        w_q[k]  <= '0;
        rank[k] <= '0;
        nxt[k]  <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            adj_q      <= adj;
            d_q        <= damping;
            base_q     <= base;
            eps_q      <= eps;
            for (int k = 0; k < N; k++) begin
              w_q[k]  <= nodeWeight[k*WIDTH +: WIDTH];
              rank[k] <= INIT;
            end
            iter_count <= '0;
            converged  <= 1'b0;
            i          <= '0;
            j          <= '0;
            acc        <= '0;
            busy       <= 1'b1;
            state      <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          acc <= acc + AW'(term);
          if (j == IW'(N - 1)) state <= S_FINISH;
          else                 j     <= j + IW'(1);
        end

        S_FINISH: begin
          nxt[i] <= fin;
          if (i == IW'(N - 1)) begin
            state <= S_COMMIT;
          end else begin
            i     <= i + IW'(1);
            j     <= '0;
            acc   <= '0;
            state <= S_ACCUM;
          end
        end

        S_COMMIT: begin
          for (int k = 0; k < N; k++) rank[k] <= nxt[k];
          iter_count <= iter_count + CW'(1);
          if (early) begin
            converged <= 1'b1;
            state     <= S_DONE;
          end else if (last_iter) begin
            converged <= 1'b0;
            state     <= S_DONE;
          end else begin
            i     <= '0;
            j     <= '0;
            acc   <= '0;
            state <= S_ACCUM;
          end
        end

        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
          for (int k = 0; k < N; k++) rank_out[k*WIDTH +: WIDTH] <= rank[k];
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_page_rank_engine.sv
// Self-checking bench for page_rank_engine: directed table, random graphs vs an
// iteration-level reference model, plus restart/reset timing sequences.
module tb_page_rank_engine;

  localparam int N      = 4;
  localparam int W      = 16;
  localparam int P      = N*(N+1)+1;
  localparam int BUDGET = 3000;
  localparam int NV     = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] adj;
  logic [63:0] nw;
  logic [15:0] damping;
  logic [15:0] base;
  logic [15:0] eps;

  logic        busy_m, done_m, conv_m;
  logic [5:0]  it_m;
  logic [63:0] rank_m;
  logic        busy_3, done_3, conv_3;
  logic [1:0]  it_3;
  logic [63:0] rank_3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  page_rank_engine #(.N(N), .WIDTH(W), .MAX_ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .adj(adj), .nodeWeight(nw),
    .damping(damping), .base(base), .eps(eps),
    .busy(busy_m), .done(done_m), .converged(conv_m), .iter_count(it_m), .rank_out(rank_m)
  );

  page_rank_engine #(.N(N), .WIDTH(W), .MAX_ITER(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .adj(adj), .nodeWeight(nw),
    .damping(damping), .base(base), .eps(eps),
    .busy(busy_3), .done(done_3), .converged(conv_3), .iter_count(it_3), .rank_out(rank_3)
  );

  typedef struct packed {
    logic [15:0] adj;
    logic [63:0] w;
    logic [15:0] d;
    logic [15:0] b;
    logic [15:0] e;
    logic [63:0] exp_rank;
    logic [31:0] exp_it;
    logic        exp_conv;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_near(input string name, input logic [15:0] act, input logic [15:0] exp,
                            input int tol);
    int df;
    n_checks++;
    df = (act > exp) ? int'(act) - int'(exp) : int'(exp) - int'(act);
    if (df > tol) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h +/- %0h", name, act, exp, tol);
    end
  endtask

  // Whole-iteration reference: ranks as plain integers, iterate until eps or the limit.
  task automatic model_run(input logic [15:0] a, input logic [63:0] w, input logic [15:0] d,
                           input logic [15:0] b, input logic [15:0] e, input int maxit,
                           output logic [63:0] r, output int it, output bit conv);
    longint rk [N];
    longint nx [N];
    longint s, v, dl, df;
    for (int k = 0; k < N; k++) rk[k] = 65536 / N;
    it   = 0;
    conv = 1'b0;
    while (it < maxit && !conv) begin
      for (int i = 0; i < N; i++) begin
        s = 0;
        for (int j = 0; j < N; j++)
          if (a[i*N+j]) s += (longint'(w[j*16 +: 16]) * rk[j]) >> 16;
        if (s > 65535) s = 65535;
        v = longint'(b) + ((longint'(d) * s) >> 16);
        nx[i] = (v > 65535) ? 65535 : v;
      end
      dl = 0;
      for (int k = 0; k < N; k++) begin
        df = (nx[k] > rk[k]) ? nx[k] - rk[k] : rk[k] - nx[k];
        if (df > dl) dl = df;
        rk[k] = nx[k];
      end
      it++;
      if (e != 0 && dl < longint'(e)) conv = 1'b1;
    end
    for (int k = 0; k < N; k++) r[k*16 +: 16] = 16'(rk[k]);
  endtask

  task automatic apply(input logic [15:0] a, input logic [63:0] w, input logic [15:0] d,
                       input logic [15:0] b, input logic [15:0] e);
    @(negedge clk);
    adj = a; nw = w; damping = d; base = b; eps = e;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy after start", busy_m, 1'b1);
  endtask

  // Counts edges after the start edge until both instances report done.
  // Extra start pulses are issued at counts p1 (adjacency also flipped) and p2.
  task automatic run_both(input int p1, input int p2, output int lat_m, output int lat_3,
                          output logic b3_late);
    lat_m   = -1;
    lat_3   = -1;
    b3_late = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      @(negedge clk);
      if (done_m && lat_m < 0) lat_m = c;
      if (done_3 && lat_3 < 0) lat_3 = c;
      if (p2 > 0 && c == p2 + 2) b3_late = busy_3;
      start = (c == p1) || (c == p2);
      if (c == p1) adj = ~adj;
      if (lat_m >= 0 && lat_3 >= 0 && c > p2 + 2) break;
    end
    start = 1'b0;
  endtask

  logic [63:0] r;
  int          it;
  bit          cv;
  int          lm, l3;
  logic        b3;

  initial begin
    reset = 1'b0; start = 1'b0; adj = '0; nw = '0; damping = '0; base = '0; eps = '0;
    repeat (3) @(negedge clk);
    check("reset busy",      busy_m, 1'b0);
    check("reset done",      done_m, 1'b0);
    check("reset converged", conv_m, 1'b0);
    check("reset iter",      it_m,   '0);
    check("reset rank_out",  rank_m, '0);
    reset = 1'b1;

    // Directed entries: textbook graph, no in-links, saturation; then random graphs.
    vecs[0] = '{16'h3B1C, 64'h8000_FFFF_8000_5555, 16'hFFFF, 16'h0000, 16'h0010, '0, 0, 1'b0};
    vecs[1] = '{16'h0000, 64'h8000_FFFF_8000_5555, 16'hD99A, 16'h099A, 16'h0001,
                {4{16'h099A}}, 2, 1'b1};
    vecs[2] = '{16'h000E, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'h0001,
                {4{16'hFFFF}}, 2, 1'b1};
    model_run(vecs[0].adj, vecs[0].w, vecs[0].d, vecs[0].b, vecs[0].e, 32, r, it, cv);
    vecs[0].exp_rank = r; vecs[0].exp_it = it; vecs[0].exp_conv = cv;
    for (int v = 3; v < NV; v++) begin
      vecs[v].adj = 16'($urandom);
      vecs[v].w   = {$urandom, $urandom};
      vecs[v].d   = 16'($urandom_range(16'h8000, 16'hFFFF));
      vecs[v].b   = 16'($urandom_range(0, 16'h2000));
      vecs[v].e   = 16'($urandom_range(0, 40));
      model_run(vecs[v].adj, vecs[v].w, vecs[v].d, vecs[v].b, vecs[v].e, 32, r, it, cv);
      vecs[v].exp_rank = r; vecs[v].exp_it = it; vecs[v].exp_conv = cv;
    end

    for (int v = 0; v < NV; v++) begin
      apply(vecs[v].adj, vecs[v].w, vecs[v].d, vecs[v].b, vecs[v].e);
      pulse_start();
      run_both(-1, -1, lm, l3, b3);
      check($sformatf("v%0d rank", v), rank_m, vecs[v].exp_rank);
      check($sformatf("v%0d iter", v), it_m, vecs[v].exp_it);
      check($sformatf("v%0d conv", v), conv_m, vecs[v].exp_conv);
      check($sformatf("v%0d latency", v), lm, vecs[v].exp_it * P + 1);
      model_run(vecs[v].adj, vecs[v].w, vecs[v].d, vecs[v].b, vecs[v].e, 3, r, it, cv);
      check($sformatf("v%0d lim3 rank", v), rank_3, r);
      check($sformatf("v%0d lim3 iter", v), it_3, it);
      check($sformatf("v%0d lim3 conv", v), conv_3, cv);
      check($sformatf("v%0d lim3 latency", v), l3, it * P + 1);
      @(negedge clk);
      check($sformatf("v%0d done one cycle", v), {done_m, done_3, busy_m, busy_3}, 4'b0000);
      if (v == 0) begin
        check("graph converged", conv_m, 1'b1);
        check_near("graph rank0", rank_m[15:0],  16'h6318, 16'h200);
        check_near("graph rank1", rank_m[31:16], 16'h2108, 16'h200);
        check_near("graph rank2", rank_m[47:32], 16'h4A52, 16'h200);
        check_near("graph rank3", rank_m[63:48], 16'h318C, 16'h200);
      end
    end

    // Iteration limit: eps disabled.
    model_run(16'h3B1C, 64'h8000_FFFF_8000_5555, 16'hFFFF, 16'h0000, 16'h0000, 3, r, it, cv);
    apply(16'h3B1C, 64'h8000_FFFF_8000_5555, 16'hFFFF, 16'h0000, 16'h0000);
    pulse_start();
    run_both(-1, -1, lm, l3, b3);
    check("limit latency",   l3, 64);
    check("limit iter",      it_3, 2'd3);
    check("limit conv",      conv_3, 1'b0);
    check("limit rank",      rank_3, r);
    check("limit32 latency", lm, 32 * P + 1);
    check("limit32 iter",    it_m, 6'd32);
    check("limit32 conv",    conv_m, 1'b0);

    // Same solve with start re-pulsed mid-solve (adjacency changed) and in the DONE cycle.
    apply(16'h3B1C, 64'h8000_FFFF_8000_5555, 16'hFFFF, 16'h0000, 16'h0000);
    pulse_start();
    run_both(30, 63, lm, l3, b3);
    adj = 16'h3B1C;
    check("repulse latency", l3, 64);
    check("repulse iter",    it_3, 2'd3);
    check("repulse rank",    rank_3, r);
    check("done-cycle start ignored", b3, 1'b0);
    check("repulse main latency", lm, 32 * P + 1);

    // Reset during ACCUM of the second iteration, then a clean solve.
    apply(vecs[0].adj, vecs[0].w, vecs[0].d, vecs[0].b, vecs[0].e);
    pulse_start();
    repeat (P + 5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midreset busy",     {busy_m, busy_3}, 2'b00);
    check("midreset done",     {done_m, done_3}, 2'b00);
    check("midreset rank_out", rank_m, '0);
    check("midreset iter",     it_m, '0);
    check("midreset lim3 rank", rank_3, '0);
    reset = 1'b1;
    pulse_start();
    run_both(-1, -1, lm, l3, b3);
    check("post-reset rank",    rank_m, vecs[0].exp_rank);
    check("post-reset iter",    it_m, vecs[0].exp_it);
    check("post-reset latency", lm, vecs[0].exp_it * P + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
